// File: rtl/io_fifo_fx_pkg.sv
// rtl/io_fifo_fx_pkg.sv - shared constants for the channelised I/O FIFO block
package io_fifo_fx_pkg;
  localparam int ERR_UFLOW = 0;
  localparam int ERR_OFLOW = 1;
endpackage

// File: rtl/io_fifo_fx_fifo_fx.sv
// rtl/io_fifo_fx_fifo_fx.sv - first-word-fall-through FIFO used for every channel
module fifo_fx #(
  parameter int NUBITS = 16,
  parameter int FDEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [NUBITS-1:0]            din,
  input  logic                         pop,
  output logic [NUBITS-1:0]            head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FDEPTH+1)-1:0]  count
);
  localparam int PW = $clog2(FDEPTH);
  localparam int CW = $clog2(FDEPTH+1);

  logic [NUBITS-1:0] mem [FDEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FDEPTH));
  assign head    = mem[rptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when its head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/io_fifo_fx.sv
// rtl/io_fifo_fx.sv - processor I/O port bank: per-channel FWFT FIFOs, status, errors, interrupt
module io_fifo_fx
  import io_fifo_fx_pkg::*;
#(
  parameter int                NUBITS = 16,
  parameter int                NUIOIN = 2,
  parameter int                NUIOOU = 2,
  parameter int                FDEPTH = 8,
  parameter logic [NUIOIN-1:0] ITRMSK = '1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      req_in,
  input  logic [((NUIOIN>1)?$clog2(NUIOIN):1)-1:0] addr_in,
  output logic [NUBITS-1:0]                         io_in,
  input  logic                                      out_en,
  input  logic [((NUIOOU>1)?$clog2(NUIOOU):1)-1:0] addr_out,
  input  logic [NUBITS-1:0]                         io_out,
  output logic                                      itr,
  input  logic [NUIOIN-1:0]                         ext_in_valid,
  input  logic [NUIOIN*NUBITS-1:0]                  ext_in_data,
  output logic [NUIOIN-1:0]                         ext_in_ready,
  output logic [NUIOOU-1:0]                         ext_out_valid,
  output logic [NUIOOU*NUBITS-1:0]                  ext_out_data,
  input  logic [NUIOOU-1:0]                         ext_out_ready,
  output logic [2*(NUIOIN+NUIOOU)-1:0]              status,
  output logic [1:0]                                err
);
  localparam int IAW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int OAW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
  localparam int CW  = $clog2(FDEPTH+1);

  logic [NUIOIN-1:0] in_empty, in_full, in_pop, in_push, in_uflow, in_empty_q;
  logic [NUIOOU-1:0] out_empty, out_full, out_pop, out_push, out_oflow;
  logic [NUBITS-1:0] in_head [NUIOIN];
  logic [CW-1:0]     in_count [NUIOIN];
  logic [CW-1:0]     out_count [NUIOOU];

  for (genvar c = 0; c < NUIOIN; c++) begin : g_in
    assign in_pop[c]   = req_in && (addr_in == IAW'(c));
    assign in_push[c]  = ext_in_valid[c] && !in_full[c];
    assign in_uflow[c] = in_pop[c] && (in_count[c] == '0);

    fifo_fx #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .push(in_push[c]), .din(ext_in_data[c*NUBITS +: NUBITS]),
      .pop(in_pop[c]), .head(in_head[c]),
      .empty(in_empty[c]), .full(in_full[c]), .count(in_count[c])
    );
  end

  for (genvar c = 0; c < NUIOOU; c++) begin : g_out
    assign out_push[c]  = out_en && (addr_out == OAW'(c));
    assign out_pop[c]   = ext_out_ready[c] && !out_empty[c];
    assign out_oflow[c] = out_push[c] && (out_count[c] == CW'(FDEPTH)) && !out_pop[c];

    fifo_fx #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .push(out_push[c]), .din(io_out),
      .pop(out_pop[c]), .head(ext_out_data[c*NUBITS +: NUBITS]),
      .empty(out_empty[c]), .full(out_full[c]), .count(out_count[c])
    );
  end

  always_comb begin
    io_in = '0;
    for (int c = 0; c < NUIOIN; c++) begin
      if (addr_in == IAW'(c) && !in_empty[c]) io_in = in_head[c];
    end
  end

  assign ext_in_ready  = ~in_full;
  assign ext_out_valid = ~out_empty;
  assign status        = {out_full, out_empty, in_full, in_empty};

  // itr fires the cycle after a masked input channel is first seen non-empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err        <= '0;
      itr        <= 1'b0;
      in_empty_q <= '1;
    end else begin
      err[ERR_UFLOW] <= err[ERR_UFLOW] | (|in_uflow);
      err[ERR_OFLOW] <= err[ERR_OFLOW] | (|out_oflow);
      in_empty_q     <= in_empty;
      itr            <= |(ITRMSK & in_empty_q & ~in_empty);
    end
  end
endmodule

// File: doc/io_fifo_fx.md
IO_FIFO_FX -- requirements
Module: io_fifo_fx

Interface
REQ-001 SHALL have parameter NUBITS, default 16, word width shared with the processor.
REQ-002 SHALL have parameter NUIOIN, default 2, number of input channels (>=1).
REQ-003 SHALL have parameter NUIOOU, default 2, number of output channels (>=1).
REQ-004 SHALL have parameter FDEPTH, default 8, words per channel FIFO, power of 2 and >=2.
REQ-005 SHALL have parameter ITRMSK, default all ones over NUIOIN bits, input channels allowed to raise itr.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, reset; asynchronous, active-low.
REQ-008 SHALL have port req_in, input, 1 bit, processor input read strobe.
REQ-009 SHALL have port addr_in, input, $clog2(NUIOIN) bits, processor input channel select.
REQ-010 SHALL have port io_in, output, NUBITS bits, head word of the selected input FIFO to the processor.
REQ-011 SHALL have port out_en, input, 1 bit, processor output write strobe.
REQ-012 SHALL have port addr_out, input, $clog2(NUIOOU) bits, processor output channel select.
REQ-013 SHALL have port io_out, input, NUBITS bits, processor output word.
REQ-014 SHALL have port itr, output, 1 bit, interrupt pulse to the processor.
REQ-015 SHALL have ports ext_in_valid (NUIOIN bits, in), ext_in_data (NUIOIN*NUBITS bits, in, channel c at bits [c*NUBITS +: NUBITS]) and ext_in_ready (NUIOIN bits, out).
REQ-016 SHALL have ports ext_out_valid (NUIOOU bits, out), ext_out_data (NUIOOU*NUBITS bits, out, same packing) and ext_out_ready (NUIOOU bits, in).
REQ-017 SHALL have port status, output, 2*(NUIOIN+NUIOOU) bits: [NUIOIN-1:0] input-empty, then input-full, then output-empty, then output-full.
REQ-018 SHALL have port err, output, 2 bits: [0] sticky input underflow, [1] sticky output overflow.

Function
REQ-019 Each channel SHALL be a first-word-fall-through FIFO; its head is visible combinationally while it is non-empty.
REQ-020 io_in SHALL equal the head of input FIFO addr_in combinationally, and SHALL be 0 when that FIFO is empty.
REQ-021 req_in=1 SHALL pop input FIFO addr_in at the clock edge; a pop of an empty FIFO SHALL leave the FIFO unchanged and set err[0].
REQ-022 ext_in_ready[c] SHALL be !full[c], computed from registered state only; a push SHALL occur when valid&ready.
REQ-023 A push and a pop on the same channel in the same cycle SHALL both take effect with the count unchanged; when the FIFO is empty, the pop is an underflow and the push still lands.
REQ-024 out_en=1 SHALL push io_out into output FIFO addr_out; when that FIFO is full (pre-edge) and not popping, the word SHALL be dropped and err[1] set.
REQ-025 A push to a full output FIFO SHALL succeed when ext_out_valid&ext_out_ready pops the same channel in the same cycle.
REQ-026 ext_out_valid[c] SHALL be !empty[c], and ext_out_data SHALL be the head word; a pop SHALL occur when valid&ready.
REQ-027 Read and write pointers SHALL be $clog2(FDEPTH) bits and wrap modulo FDEPTH; the count SHALL be $clog2(FDEPTH+1) bits and range 0..FDEPTH.
REQ-028 itr SHALL be a one-cycle registered pulse, one cycle after any channel c with ITRMSK[c]=1 goes from empty to non-empty; simultaneous transitions SHALL give a single pulse.
REQ-029 err bits SHALL stay set until reset.
REQ-030 An addr_in or addr_out value at or beyond the channel count SHALL be ignored for push/pop; io_in SHALL then be 0.

Reset
REQ-031 rst=0 SHALL asynchronously clear all pointers, counts, err and itr.
REQ-032 During reset, all FIFOs SHALL read empty, ext_in_ready SHALL be all ones, ext_out_valid SHALL be 0 and io_in SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL discard FIFO contents; no partial word SHALL survive.
REQ-034 The first push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-035 No shared package is needed; the widths derived from parameters SHALL be local parameters.
REQ-036 One sub-module, fifo_fx (parametrised NUBITS/FDEPTH, FWFT, push/pop/empty/full/count), SHALL be instantiated per channel through generate loops.
REQ-037 Storage SHALL be register arrays with no read latency.

Verification
REQ-038 Fill: push 8 words 1..8 to input ch0 with FDEPTH=8 -> ext_in_ready[0]=0 and full flag set; 8 req_in reads return 1..8 in order, then empty.
REQ-039 Underflow: req_in on empty ch1 -> io_in=0, err[0]=1, which stays set through 20 idle cycles.
REQ-040 Same-cycle: with ch0 holding 3 words, push 0x55 and pop in one cycle -> count stays 3; 0x55 is read fourth.
REQ-041 Overflow: 8 out_en writes to out ch1 with ext_out_ready=0, then write 0xAA -> 0xAA dropped, err[1]=1; drain yields the first 8 words only.
REQ-042 Interrupt: ITRMSK=2'b10, push to ch0 -> no itr; push to empty ch1 -> itr high for exactly one cycle.
REQ-043 Reset: assert rst=0 mid-stream with 5 words queued -> status shows all empty, ext_out_valid=0 and err=0 immediately, with no clock edge.
